// File: rtl/data_mem_resp_pkg.sv
// Shared size encodings, FSM state codes and the size-to-mask helper for data_mem_resp.
package pkgs;

  localparam int unsigned DataW = 19;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StWait = 2'd1;
  localparam state_t StResp = 2'd2;

  // Reserved encoding 2'b10 selects the full word.
  function automatic logic [DataW-1:0] size_mask(input logic [1:0] sz);
    logic [DataW-1:0] m;
    case (sz)
      SzByte:  m = 19'h000FF;
      SzHalf:  m = 19'h0FFFF;
      SzWord:  m = 19'h7FFFF;
      default: m = 19'h7FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port storage: bit-masked synchronous write, registered masked read.
module dmem_array #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = 10,
  parameter int unsigned DataW = 19
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [DataW-1:0] wmask_i,
  input  logic [DataW-1:0] rmask_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i] & rmask_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: sized reads/writes, range check, one-cycle response strobe.
// Wait states exist only when DMEM_WAIT_STATES_EN is defined; otherwise WAIT_CYCLES is ignored.
module data_mem_resp
  import pkgs::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [18:0] BASE_ADDR   = 19'h0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_req_i,
  input  logic [18:0] mem_addr_i,
  input  logic [1:0]  mem_byte_en_i,
  input  logic        mem_wr_i,
  input  logic [18:0] mem_wr_data_i,
  output logic [18:0] mem_rd_data_o,
  output logic        mem_rdy_o,
  output logic        mem_err_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t      state_q, state_d;
  logic [18:0] addr_q, wdata_q;
  logic [1:0]  be_q;
  logic        wr_q, err_q;
  logic        capture, go_resp, wait_done, in_range;
  logic [18:0] acc_addr, acc_wdata, idx;
  logic [1:0]  acc_be;
  logic        acc_wr;

  assign capture = (state_q == StIdle) && mem_req_i;

`ifdef DMEM_WAIT_STATES_EN
  localparam bit         WaitZero = (WAIT_CYCLES == 0);
  localparam logic [3:0] WaitLoad = WaitZero ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (capture) begin
      cnt_d = WaitLoad;
    end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wait_done = (cnt_q == 4'd0);
`else
  // Always zero wait states in this build; the term only keeps WAIT_CYCLES referenced.
  localparam bit WaitZero = 1'b1 | (WAIT_CYCLES == 0);

  assign wait_done = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    go_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_req_i) begin
          if (WaitZero) begin
            state_d = StResp;
            go_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (wait_done) begin
          state_d = StResp;
          go_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= go_resp & ~in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q  <= mem_addr_i;
      be_q    <= mem_byte_en_i;
      wr_q    <= mem_wr_i;
      wdata_q <= mem_wr_data_i;
    end
  end

  // A zero-wait access completes straight from IDLE, before the holding registers load.
  assign acc_addr  = (state_q == StIdle) ? mem_addr_i    : addr_q;
  assign acc_be    = (state_q == StIdle) ? mem_byte_en_i : be_q;
  assign acc_wr    = (state_q == StIdle) ? mem_wr_i      : wr_q;
  assign acc_wdata = (state_q == StIdle) ? mem_wr_data_i : wdata_q;

  assign idx      = acc_addr - BASE_ADDR;
  assign in_range = (acc_addr >= BASE_ADDR) && ({13'd0, idx} < DEPTH);

  dmem_array #(
    .Depth(DEPTH),
    .AddrW(AddrW),
    .DataW(DataW)
  ) u_array (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .we_i   (go_resp & acc_wr & in_range & reset_n),
    .re_i   (go_resp & ~acc_wr & reset_n),
    .addr_i (idx[AddrW-1:0]),
    .wdata_i(acc_wdata),
    .wmask_i(size_mask(acc_be)),
    .rmask_i(in_range ? size_mask(acc_be) : 19'h0),
    .rdata_o(mem_rd_data_o)
  );

  assign mem_rdy_o = (state_q == StResp);
  assign mem_err_o = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed table-driven bench for data_mem_resp, with stream and reset-abort sequences.
module tb_data_mem_resp;

  localparam int unsigned WaitCfg = 2;
`ifdef DMEM_WAIT_STATES_EN
  localparam int EffWait = WaitCfg;
`else
  localparam int EffWait = 0;
`endif
  localparam int Period = EffWait + 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req_i;
  logic [18:0] mem_addr_i;
  logic [1:0]  mem_byte_en_i;
  logic        mem_wr_i;
  logic [18:0] mem_wr_data_i;
  logic [18:0] mem_rd_data_o;
  logic        mem_rdy_o;
  logic        mem_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  be;
    logic [18:0] addr;
    logic [18:0] wdata;
    logic [18:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [19];

  data_mem_resp #(
    .DEPTH      (1024),
    .BASE_ADDR  (19'h0),
    .WAIT_CYCLES(WaitCfg)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_req_i    (mem_req_i),
    .mem_addr_i   (mem_addr_i),
    .mem_byte_en_i(mem_byte_en_i),
    .mem_wr_i     (mem_wr_i),
    .mem_wr_data_i(mem_wr_data_i),
    .mem_rd_data_o(mem_rd_data_o),
    .mem_rdy_o    (mem_rdy_o),
    .mem_err_o    (mem_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One request from IDLE; returns with the DUT back in IDLE.
  task automatic access(input logic w, input logic [1:0] b, input logic [18:0] a,
                        input logic [18:0] d, input logic [18:0] exp_rd, input logic exp_err,
                        input string nm);
    int n;
    @(negedge clk);
    mem_wr_i      = w;
    mem_byte_en_i = b;
    mem_addr_i    = a;
    mem_wr_data_i = d;
    mem_req_i     = 1'b1;
    @(posedge clk);
    #1;
    mem_req_i = 1'b0;
    n = 0;
    while (!mem_rdy_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, "_latency"}, n, EffWait);
    check({nm, "_rdata"}, mem_rd_data_o, exp_rd);
    check({nm, "_err"}, mem_err_o, exp_err);
    @(posedge clk);
    #1;
    check({nm, "_rdy_one_cycle"}, mem_rdy_o, 1'b0);
    check({nm, "_err_clear"}, mem_err_o, 1'b0);
  endtask

  initial begin
    int pulses;
    int last;

    vecs[0]  = '{1'b1, 2'b11, 19'h00010, 19'h5A5A5, 19'h00000, 1'b0};
    vecs[1]  = '{1'b0, 2'b11, 19'h00010, 19'h00000, 19'h5A5A5, 1'b0};
    vecs[2]  = '{1'b1, 2'b11, 19'h00020, 19'h7FFFF, 19'h5A5A5, 1'b0};
    vecs[3]  = '{1'b1, 2'b00, 19'h00020, 19'h3AB12, 19'h5A5A5, 1'b0};
    vecs[4]  = '{1'b0, 2'b11, 19'h00020, 19'h00000, 19'h7FF12, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 19'h00020, 19'h00000, 19'h0FF12, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 19'h00020, 19'h00000, 19'h00012, 1'b0};
    vecs[7]  = '{1'b1, 2'b01, 19'h00020, 19'h4BEEF, 19'h00012, 1'b0};
    vecs[8]  = '{1'b0, 2'b10, 19'h00020, 19'h00000, 19'h7BEEF, 1'b0};
    vecs[9]  = '{1'b1, 2'b10, 19'h00030, 19'h12345, 19'h7BEEF, 1'b0};
    vecs[10] = '{1'b0, 2'b11, 19'h00030, 19'h00000, 19'h12345, 1'b0};
    vecs[11] = '{1'b1, 2'b11, 19'h00000, 19'h00777, 19'h12345, 1'b0};
    vecs[12] = '{1'b1, 2'b11, 19'h00400, 19'h11111, 19'h12345, 1'b1};
    vecs[13] = '{1'b0, 2'b11, 19'h00400, 19'h00000, 19'h00000, 1'b1};
    vecs[14] = '{1'b0, 2'b11, 19'h00000, 19'h00000, 19'h00777, 1'b0};
    vecs[15] = '{1'b1, 2'b11, 19'h003FF, 19'h2AAAA, 19'h00777, 1'b0};
    vecs[16] = '{1'b0, 2'b11, 19'h003FF, 19'h00000, 19'h2AAAA, 1'b0};
    vecs[17] = '{1'b0, 2'b11, 19'h7FFFF, 19'h00000, 19'h00000, 1'b1};
    vecs[18] = '{1'b0, 2'b11, 19'h00010, 19'h00000, 19'h5A5A5, 1'b0};

    reset_n       = 1'b0;
    mem_req_i     = 1'b0;
    mem_addr_i    = '0;
    mem_byte_en_i = 2'b11;
    mem_wr_i      = 1'b0;
    mem_wr_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", mem_rdy_o, 1'b0);
    check("reset_err", mem_err_o, 1'b0);
    check("reset_rdata", mem_rd_data_o, 19'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      access(vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
             vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Request held high: one response per period, every one a fresh read.
    @(negedge clk);
    mem_wr_i      = 1'b0;
    mem_byte_en_i = 2'b11;
    mem_addr_i    = 19'h10;
    mem_req_i     = 1'b1;
    pulses = 0;
    last   = -1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (mem_rdy_o) begin
        pulses++;
        check("stream_rdata", mem_rd_data_o, 19'h5A5A5);
        check("stream_err", mem_err_o, 1'b0);
        if (last >= 0) check("stream_period", e - last, Period);
        else check("stream_first", e, EffWait);
        last = e;
      end
    end
    mem_req_i = 1'b0;
    check("stream_count", pulses, (39 - EffWait) / Period + 1);
    repeat (Period + 1) @(posedge clk);

    // Reset abandons a write in flight (in the WAIT cycle when wait states exist).
    @(negedge clk);
    mem_wr_i      = 1'b1;
    mem_byte_en_i = 2'b11;
    mem_addr_i    = 19'h30;
    mem_wr_data_i = 19'h0ABCD;
    mem_req_i     = 1'b1;
    if (EffWait == 0) reset_n = 1'b0;
    @(posedge clk);
    #1;
    mem_req_i = 1'b0;
    reset_n   = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rdy", mem_rdy_o, 1'b0);
    check("rst_rdata_clear", mem_rd_data_o, 19'h0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (mem_rdy_o) pulses++;
    end
    check("rst_no_response", pulses, 0);
    access(1'b0, 2'b11, 19'h30, 19'h0, 19'h12345, 1'b0, "rst_keep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 19-bit words stored.
REQ-002 SHALL have parameter BASE_ADDR, default 19'h0, word address of entry 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response (0..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port mem_req_i  input  1  access request from the CPU data port.
REQ-007 SHALL have port mem_addr_i  input  19  word address.
REQ-008 SHALL have port mem_byte_en_i  input  2  access size: 00 byte [7:0], 01 half [15:0], 11 word [18:0], 10 reserved.
REQ-009 SHALL have port mem_wr_i  input  1  1 write, 0 read.
REQ-010 SHALL have port mem_wr_data_i  input  19  write data.
REQ-011 SHALL have port mem_rd_data_o  output  19  read data, zero-extended to the access size.
REQ-012 SHALL have port mem_rdy_o  output  1  one-cycle response strobe.
REQ-013 SHALL have port mem_err_o  output  1  out-of-range flag, qualified by mem_rdy_o.

Function
REQ-014 SHALL implement FSM IDLE, WAIT, RESP; reset state IDLE.
REQ-015 IDLE with mem_req_i=1 SHALL capture addr, byte_en, wr and wr_data into holding registers and go to WAIT, or to RESP when the effective wait count is 0.
REQ-016 WAIT SHALL load a 4-bit counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and go to RESP in the cycle after it reads 0.
REQ-017 RESP SHALL last exactly one cycle with mem_rdy_o=1, then return to IDLE. Back-to-back requests SHALL have a minimum period of WAIT_CYCLES+2 cycles.
REQ-018 Request inputs SHALL be ignored outside IDLE. A request held high through RESP SHALL be re-captured as a new request in the following IDLE cycle.
REQ-019 The index SHALL be mem_addr_i-BASE_ADDR. It is in range when mem_addr_i>=BASE_ADDR and the index is <DEPTH. There is no wrap-around.
REQ-020 In-range write SHALL commit on the edge entering RESP. It SHALL merge only the sized field (byte [7:0], half [15:0], word all 19 bits) and preserve the other bits. Reserved size 10 SHALL be treated as word.
REQ-021 In-range read SHALL register the sized field, zero-extended, into mem_rd_data_o on the edge entering RESP.
REQ-022 mem_rd_data_o SHALL hold its value until the next read response. Write responses SHALL NOT change it.
REQ-023 Out-of-range access SHALL assert mem_err_o with mem_rdy_o, perform no write, and return read data 19'h0.
REQ-024 mem_err_o and mem_rdy_o SHALL be 0 in every cycle outside RESP.

Reset
REQ-025 reset_n=0 SHALL force state IDLE, counter 0, mem_rdy_o=0, mem_err_o=0, mem_rd_data_o=0 on the next edge.
REQ-026 Reset mid-transaction SHALL abandon the transaction: no write commit and no response.
REQ-027 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro DMEM_WAIT_STATES_EN defined, WAIT state and counter SHALL exist per REQ-016.
REQ-029 Without DMEM_WAIT_STATES_EN, WAIT_CYCLES SHALL be ignored and treated as 0. The effective flow is IDLE->RESP->IDLE, 2-cycle period, with no counter logic.

Structure
REQ-030 Size encodings (BYTE, HALF, WORD) and the FSM state enum SHALL live in package pkgs.
REQ-031 Storage SHALL be a sub-module dmem_array: single port, synchronous write with a 19-bit bit-mask, registered read.

Verification
REQ-032 WAIT_CYCLES=2: word write 19'h5A5A5 to addr 19'h10, then word read of 19'h10 -> mem_rdy_o pulses 3 cycles after each capture, and the read returns 19'h5A5A5.
REQ-033 Storage holds 19'h7FFFF at addr 19'h20: byte write 8'h12 to 19'h20, then word read -> returns 19'h7FF12. Half read -> returns 19'h0FF12.
REQ-034 DEPTH=1024, BASE_ADDR=0: write to addr 19'h400 -> mem_err_o=1 with mem_rdy_o and no write; read of 19'h400 -> data 0, err 1. Read of 19'h3FF -> err 0.
REQ-035 mem_req_i held high continuously -> exactly one mem_rdy_o per WAIT_CYCLES+2 cycles, with no lost or duplicated transactions.
REQ-036 reset_n low in the WAIT cycle of a write to 19'h30 -> no mem_rdy_o, and a later read of 19'h30 returns the pre-write value.
REQ-037 Build without DMEM_WAIT_STATES_EN, WAIT_CYCLES=5 -> mem_rdy_o in the cycle after capture, every response.
